// File: rtl/wired_mdu_share_arb_pkg.sv
// Shared types and defaults for the MDU share arbiter.
// Holds the owner index type, the default sizing, and the IQ<->unit payload structs.
package wired_mdu_share_arb_pkg;

    localparam int MDU_ARB_N_REQ        = 2;
    localparam int MDU_ARB_MAX_INFLIGHT = 4;

    // Index of the IQ that owns an accepted request.
    typedef logic [$clog2(MDU_ARB_N_REQ)-1:0] mdu_arb_owner_t;

    // Request issued by an MDU IQ toward the execution unit.
    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  tag;
        logic [15:0] src_a;
        logic [15:0] src_b;
    } iq_mdu_req_t;

    // Response returned by the execution unit.
    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } iq_mdu_resp_t;

endpackage

// File: rtl/wired_mdu_arb_owner_fifo.sv
// Ownership FIFO: remembers which IQ issued each in-flight request, oldest at the head.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module wired_mdu_arb_owner_fifo #(
    parameter  int W     = 1,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = CW'(r_wr_ptr - r_rd_ptr);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Advance read/write pointers; flush and reset both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care while the slot is not valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/wired_mdu_share_arb.sv
// Shares one in-order MDU execution unit between N_REQ issue queues.
// Round-robin grant on the request side; an ownership FIFO steers each response back to its issuer.
// Optional WIRED_MDU_ARB_REQ_BUF_EN: 2-entry skid buffer between the grant and ex_* (1 cycle request latency).
// Valid/ready: a transfer happens on any edge where valid and ready are both high; valid never waits on ready.
module wired_mdu_share_arb
    import wired_mdu_share_arb_pkg::*;
#(
    parameter  int N_REQ        = MDU_ARB_N_REQ,
    parameter  int MAX_INFLIGHT = MDU_ARB_MAX_INFLIGHT,
    localparam int OW           = $clog2(N_REQ),
    localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  iq_mdu_req_t        req_i [N_REQ],
    output logic [N_REQ-1:0]   resp_valid_o,
    input  logic [N_REQ-1:0]   resp_ready_i,
    output iq_mdu_resp_t       resp_o,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output iq_mdu_req_t        ex_req_o,
    input  logic               ex_valid_i,
    output logic               ex_ready_o,
    input  iq_mdu_resp_t       ex_resp_i,
    output logic [CW-1:0]      inflight_o,
    output logic               busy_o
);

    logic [OW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_inflight;
    logic             w_gnt_valid;
    logic [OW-1:0]    w_gnt_idx;
    logic [N_REQ-1:0] w_gnt_onehot;
    logic             w_take;
    logic             w_ex_accept;
    logic [CW-1:0]    w_staged;
    logic [OW-1:0]    w_owner;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_fifo_count;
    logic             w_pop;
    logic [N_REQ-1:0] w_owner_onehot;

    // Index k positions after base, wrapping modulo N_REQ.
    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return OW'(s);
    endfunction

    // Round-robin search for the first valid requester starting at the rr pointer.
    always_comb begin
        w_gnt_valid  = 1'b0;
        w_gnt_idx    = '0;
        w_gnt_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_gnt_valid && req_valid_i[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = rr_idx(r_rr_ptr, k);
            end
        end
        if (w_gnt_valid) w_gnt_onehot[w_gnt_idx] = 1'b1;
    end

`ifdef WIRED_MDU_ARB_REQ_BUF_EN
    logic             r_sb_wr;
    logic             r_sb_rd;
    logic [1:0]       r_sb_cnt;
    iq_mdu_req_t      r_sb_data [2];
    logic             w_issue_ok;
    logic [CW:0]      w_committed;

    // Staged requests already own a FIFO slot, so they count against the limit.
    assign w_staged    = CW'(r_sb_cnt);
    assign w_committed = {1'b0, r_inflight} + {1'b0, w_staged};
    assign w_issue_ok  = (w_committed < (CW+1)'(MAX_INFLIGHT)) & (r_sb_cnt != 2'd2)
                       & ~w_full & ~flush_i;
    assign w_take      = w_gnt_valid & w_issue_ok;
    assign req_ready_o = w_gnt_onehot & {N_REQ{w_issue_ok}};
    assign ex_valid_o  = (r_sb_cnt != 2'd0) & ~flush_i;
    assign ex_req_o    = ex_valid_o ? r_sb_data[r_sb_rd] : '0;
    assign w_ex_accept = ex_valid_o & ex_ready_i;

    // Skid buffer occupancy and pointers; emptied by flush and reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_sb_wr  <= 1'b0;
            r_sb_rd  <= 1'b0;
            r_sb_cnt <= 2'd0;
        end else begin
            if (w_take)      r_sb_wr <= ~r_sb_wr;
            if (w_ex_accept) r_sb_rd <= ~r_sb_rd;
            case ({w_take, w_ex_accept})
                2'b10:   r_sb_cnt <= r_sb_cnt + 2'd1;
                2'b01:   r_sb_cnt <= r_sb_cnt - 2'd1;
                default: r_sb_cnt <= r_sb_cnt;
            endcase
        end
    end

    // Skid buffer payload capture at grant.
    always_ff @(posedge clk) begin
        if (w_take) r_sb_data[r_sb_wr] <= req_i[w_gnt_idx];
    end
`else
    logic             w_issue_ok;

    // Pass-through: only the registered count gates issue, so a same-cycle pop frees nothing.
    assign w_staged    = '0;
    assign w_issue_ok  = (r_inflight < CW'(MAX_INFLIGHT)) & ~w_full & ~flush_i;
    assign ex_valid_o  = w_gnt_valid & w_issue_ok;
    assign ex_req_o    = ex_valid_o ? req_i[w_gnt_idx] : '0;
    assign req_ready_o = w_gnt_onehot & {N_REQ{ex_ready_i & w_issue_ok}};
    assign w_ex_accept = ex_valid_o & ex_ready_i;
    assign w_take      = w_ex_accept;
`endif

    wired_mdu_arb_owner_fifo #(
        .W     (OW),
        .DEPTH (MAX_INFLIGHT)
    ) u_owner_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_take),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .i_data  (w_gnt_idx),
        .o_data  (w_owner),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // Owner decode for response steering.
    always_comb begin
        w_owner_onehot          = '0;
        w_owner_onehot[w_owner] = 1'b1;
    end

    // Responses go only to the FIFO head owner; stray (empty) or flush-cycle responses are drained silently.
    assign resp_o       = ex_resp_i;
    assign resp_valid_o = w_owner_onehot & {N_REQ{ex_valid_i & ~w_empty & ~flush_i}};
    assign ex_ready_o   = (~w_empty & resp_ready_i[w_owner] & ~flush_i)
                        | (ex_valid_i & (w_empty | flush_i));
    assign w_pop        = ex_valid_i & ~w_empty & resp_ready_i[w_owner] & ~flush_i;

    assign inflight_o   = r_inflight;
    assign busy_o       = (r_inflight != '0) | (w_staged != '0);

    // Outstanding-request counter: +1 on unit accept, -1 on response handshake.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_inflight <= '0;
        end else begin
            case ({w_ex_accept, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Round-robin pointer moves past the granted IQ; flush keeps it, reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_take) begin
            r_rr_ptr <= rr_idx(w_gnt_idx, 1);
        end
    end

    // A response with no owner on record is a protocol error from the unit.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_valid_i && w_empty && !flush_i));

    // Fifo count is redundant with the inflight/staged bookkeeping; kept visible for checkers.
    logic w_unused_count;
    assign w_unused_count = ^w_fifo_count;

endmodule
